// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory arbiter and its picker.
package cpu_pkg;

  // Arbiter FSM states: waiting for a request, memory transaction in
  // flight, and the one-cycle response slot.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Requester indices: CPU load/store path and loader/debug master.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone requester always wins;
// on a tie the port that was not granted last time wins.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  // Select the winner from the request vector and the previous grant.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_CPU;
    case (req)
      2'b01:   gnt_idx = PORT_CPU;
      2'b10:   gnt_idx = PORT_DBG;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU (port 0) and the
// loader/debug master (port 1). One outstanding memory transaction, all
// outputs registered, hung transactions aborted with err_o after TIMEOUT.
//
// Handshake: a port raises req_i[p] with we/addr/wdata stable and holds it
// until it sees ack_o[p] (a single-cycle pulse, with err_o and rdata_o
// valid in that same cycle); in the following cycle it must drop req_i[p]
// or present a new transaction. Dropping req_i mid-transaction does not
// cancel it. On the memory side mem_req_o stays high with stable
// we/addr/wdata until mem_ack_i is seen for one cycle.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [1:0]          ack_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output arb_state_t          dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              winner_q, winner_d;
  logic              last_q, last_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              gnt_idx;
  logic              gnt_valid;

  rr_arb2 u_rr_arb2 (
    .req       (req_i),
    .last      (last_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Next-state and next-output logic; every register holds by default and
  // the response pulse/error clear unless explicitly set.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    winner_d    = winner_q;
    last_d      = last_q;
    ack_d       = 2'b00;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d     = BUSY;
          winner_d    = gnt_idx;
          last_d      = gnt_idx;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = we_i[gnt_idx];
          mem_addr_d  = gnt_idx ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
          mem_wdata_d = gnt_idx ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
        end
      end
      BUSY: begin
        // An ack arriving on the threshold cycle still counts as success.
        if (mem_ack_i) begin
          state_d   = RESP;
          rdata_d   = mem_rdata_i;
          err_d     = 1'b0;
          ack_d     = {winner_q, ~winner_q};
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          rdata_d   = '0;
          err_d     = 1'b1;
          ack_d     = {winner_q, ~winner_q};
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        // Requests are ignored here so a stale req_i is never regranted.
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      winner_q    <= PORT_CPU;
      last_q      <= PORT_DBG;
      ack_q       <= 2'b00;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      winner_q    <= winner_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus hand-written sequences, a
// latency-programmable memory model, and a scoreboard on the ack side.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [1:0]          req_i = '0;
  logic [1:0]          we_i = '0;
  logic [2*ADDR_W-1:0] addr_i = '0;
  logic [2*DATA_W-1:0] wdata_i = '0;
  logic [1:0]          ack_o;
  logic                err_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_ack_i = 1'b0;
  logic [DATA_W-1:0]   mem_rdata_i = '0;
  arb_state_t          dbg_state_o;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .dbg_state_o (dbg_state_o)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // scoreboard entry: [35:34] ack mask, [33] err, [32] check rdata, [31:0] rdata
  logic [35:0] exp_q[$];

  // memory model contents and the bench's own reference copy
  logic [31:0] mem_arr[64];
  logic [31:0] ref_mem[64];
  int          lat_cfg = 0;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = 32'hA500_0000 + 32'(i);
      ref_mem[i] = 32'hA500_0000 + 32'(i);
    end
    mem_arr[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
  end

  // memory model: acks in the (lat_cfg+1)-th cycle of a request
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      if (mem_req_o && rst_n) begin
        if (busy_cnt == lat_cfg) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_arr[mem_addr_o[7:2]];
          if (mem_we_o) mem_arr[mem_addr_o[7:2]] = mem_wdata_o;
        end
        busy_cnt++;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // monitor: every ack pops one expected completion
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk_i);
      if (ack_o != 2'b00) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack got ack=%b err=%b rdata=%h, none expected", ack_o, err_o, rdata_o);
        end else begin
          e = exp_q.pop_front();
          if (ack_o != e[35:34] || err_o != e[33] || (e[32] && rdata_o != e[31:0])) begin
            n_fail++;
            $display("FAIL completion got ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h (checked=%b)",
                     ack_o, err_o, rdata_o, e[35:34], e[33], e[31:0], e[32]);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1, d0, d1;
    int          lat;
    logic        first;
  } vec_t;

  vec_t vecs[9];

  task automatic push_exp(input logic p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int lat);
    logic [35:0] e;
    e[35:34] = p ? 2'b10 : 2'b01;
    if (lat >= TIMEOUT) begin
      e[33] = 1'b1; e[32] = 1'b1; e[31:0] = '0;
    end else if (w) begin
      e[33] = 1'b0; e[32] = 1'b0; e[31:0] = '0;
      ref_mem[a[7:2]] = d;
    end else begin
      e[33] = 1'b0; e[32] = 1'b1; e[31:0] = ref_mem[a[7:2]];
    end
    exp_q.push_back(e);
  endtask

  // driver: apply one vector, check ack timing, drop each port on its ack
  task automatic run_vec(input vec_t v);
    logic [1:0] pending;
    logic       p;
    int         m, t, exp_t;
    @(negedge clk_i);
    lat_cfg = v.lat;
    req_i   = v.req;
    we_i    = v.we;
    addr_i  = {v.a1, v.a0};
    wdata_i = {v.d1, v.d0};
    p = v.first;
    push_exp(p, v.we[p], p ? v.a1 : v.a0, p ? v.d1 : v.d0, v.lat);
    if (v.req == 2'b11) begin
      p = ~v.first;
      push_exp(p, v.we[p], p ? v.a1 : v.a0, p ? v.d1 : v.d0, v.lat);
    end
    m = (v.lat < TIMEOUT - 1) ? v.lat : TIMEOUT - 1;
    pending = v.req;
    exp_t = m + 2;
    t = 0;
    while (pending != 2'b00 && t < 200) begin
      @(negedge clk_i);
      t++;
      if ((ack_o & pending) != 2'b00) begin
        n_vec++;
        if (t != exp_t) begin
          n_fail++;
          $display("FAIL ack_time got cycle %0d, want cycle %0d (ack=%b)", t, exp_t, ack_o);
        end
        pending = pending & ~ack_o;
        req_i   = req_i & ~ack_o;
        exp_t   = t + 3 + m;
      end
    end
    if (pending != 2'b00) begin
      n_vec++;
      n_fail++;
      $display("FAIL ack_budget got pending=%b after %0d cycles, want 00", pending, t);
    end
    req_i = 2'b00;
  endtask

  task automatic check_idle_outputs(input string name);
    n_vec++;
    if ({ack_o, err_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} != '0 ||
        dbg_state_o != IDLE) begin
      n_fail++;
      $display("FAIL %s got ack=%b err=%b rdata=%h mreq=%b mwe=%b maddr=%h mwdata=%h state=%0d, want all 0 / IDLE",
               name, ack_o, err_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, dbg_state_o);
    end
  endtask

  initial begin
    int seen;
    vec_t v;
    //         req    we     a0     a1     d0            d1            lat first
    vecs[0] = '{2'b11, 2'b01, 32'h20, 32'h24, 32'h5,        32'h0,        0,  1'b0};
    vecs[1] = '{2'b01, 2'b00, 32'h10, 32'h0,  32'h0,        32'h0,        0,  1'b0};
    vecs[2] = '{2'b11, 2'b00, 32'h20, 32'h28, 32'h0,        32'h0,        2,  1'b1};
    vecs[3] = '{2'b10, 2'b10, 32'h0,  32'h28, 32'h0,        32'h1234,     1,  1'b1};
    vecs[4] = '{2'b11, 2'b00, 32'h28, 32'h2C, 32'h0,        32'h0,        3,  1'b0};
    vecs[5] = '{2'b01, 2'b00, 32'h30, 32'h0,  32'h0,        32'h0,        16, 1'b0};
    vecs[6] = '{2'b10, 2'b00, 32'h0,  32'h34, 32'h0,        32'h0,        15, 1'b1};
    vecs[7] = '{2'b01, 2'b01, 32'h34, 32'h0,  32'h0000CAFE, 32'h0,        20, 1'b0};
    vecs[8] = '{2'b10, 2'b00, 32'h0,  32'h34, 32'h0,        32'h0,        0,  1'b1};

    repeat (3) @(negedge clk_i);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // port 1 held continuously, port 0 re-presents: expect 0,1,0,1
    @(negedge clk_i);
    lat_cfg = 0;
    we_i    = 2'b00;
    addr_i  = {32'h44, 32'h40};
    req_i   = 2'b11;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, 0);
    push_exp(1'b1, 1'b0, 32'h44, 32'h0, 0);
    push_exp(1'b0, 1'b0, 32'h40, 32'h0, 0);
    push_exp(1'b1, 1'b0, 32'h44, 32'h0, 0);
    seen = 0;
    for (int t = 0; t < 100 && seen < 4; t++) begin
      @(negedge clk_i);
      if (ack_o != 2'b00) begin
        seen++;
        if (seen == 4) req_i = 2'b00;
      end
    end
    req_i = 2'b00;
    n_vec++;
    if (seen != 4) begin
      n_fail++;
      $display("FAIL alternation_count got %0d acks, want 4", seen);
    end

    // reset during BUSY: transaction vanishes, outputs clear at once
    @(negedge clk_i);
    lat_cfg = 100;
    we_i    = 2'b00;
    addr_i  = {32'h0, 32'h50};
    req_i   = 2'b01;
    repeat (3) @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_busy");
    req_i = 2'b00;
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    check_idle_outputs("post_reset_idle");

    // first tie after reset goes to port 0
    v = '{2'b11, 2'b00, 32'h48, 32'h4C, 32'h0, 32'h0, 0, 1'b0};
    run_vec(v);

    repeat (4) @(negedge clk_i);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
